// File: rtl/muldiv_seq_pkg.sv
// Opcode and FSM state encodings shared by the iterative multiply/divide unit.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        MD_OP_MUL  = 2'd0,
        MD_OP_IMUL = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_IDIV = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_ST_IDLE = 3'd0,
        MD_ST_PREP = 3'd1,
        MD_ST_CALC = 3'd2,
        MD_ST_FIX  = 3'd3,
        MD_ST_DONE = 3'd4
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_OP_IMUL) || (op == MD_OP_IDIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_IDIV);
    endfunction

endpackage

// File: rtl/muldiv_seq_twos.sv
// Conditional two's-complement negate; doubles as absolute value when neg is the sign bit.
module twos_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    assign res = neg ? (~val + ONE) : val;
endmodule

// File: rtl/muldiv_seq.sv
// Iterative radix-2 MUL/IMUL/DIV/IDIV unit with EDX:EAX-style double-width operands
// and a valid/ready handshake on both sides.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opnd_hi,
    input  logic [WIDTH-1:0] opnd_lo,
    input  logic [WIDTH-1:0] opnd_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_cf_of,
    output logic             res_de,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e          state, state_nxt;
    md_op_e             op_q;
    logic [2*WIDTH-1:0] dvd_q, acc, a_raw, a_mag, acc_step, prod;
    logic [WIDTH-1:0]   src_q, opb, b_mag, quot, rem, sub;
    logic [WIDTH:0]     add_sum, shl;
    logic [CW-1:0]      cnt;
    logic               sign_q, sign_r, is_div, is_sgn, a_neg, b_neg;
    logic               early_de, accept, q_bit, idiv_ovf, cf_of;

    assign is_div = md_is_div(op_q);
    assign is_sgn = md_is_signed(op_q);
    assign accept = in_valid & in_ready;

    // PREP: multiplicand is sign/zero-extended so one 2W abs serves both op classes
    assign a_raw = is_div ? dvd_q
                          : {{WIDTH{is_sgn & dvd_q[WIDTH-1]}}, dvd_q[WIDTH-1:0]};
    assign a_neg = is_sgn & a_raw[2*WIDTH-1];
    assign b_neg = is_sgn & src_q[WIDTH-1];

    twos_abs #(.WIDTH(2*WIDTH)) u_abs_a (.val(a_raw), .neg(a_neg), .res(a_mag));
    twos_abs #(.WIDTH(WIDTH))   u_abs_b (.val(src_q), .neg(b_neg), .res(b_mag));

    assign early_de = is_div & ((b_mag == '0) | (a_mag[2*WIDTH-1:WIDTH] >= b_mag));

    // CALC: acc holds {partial, multiplier} for MUL and {remainder, quotient} for DIV
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    assign shl     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign q_bit   = shl >= {1'b0, opb};
    assign sub     = shl[WIDTH-1:0] - opb;

    always_comb begin
        acc_step = acc;
        if (is_div) begin
            acc_step = q_bit ? {sub, acc[WIDTH-2:0], 1'b1}
                             : {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = acc[0] ? {add_sum, acc[WIDTH-1:1]}
                              : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
        end
    end

    // FIX: sign restoration and range checks
    twos_abs #(.WIDTH(2*WIDTH)) u_neg_p (.val(acc), .neg(sign_q), .res(prod));
    twos_abs #(.WIDTH(WIDTH))   u_neg_q (.val(acc[WIDTH-1:0]), .neg(sign_q), .res(quot));
    twos_abs #(.WIDTH(WIDTH))   u_neg_r (.val(acc[2*WIDTH-1:WIDTH]), .neg(sign_r), .res(rem));

    assign idiv_ovf = (op_q == MD_OP_IDIV) &
                      (sign_q ? (acc[WIDTH-1:0] > HALF) : (acc[WIDTH-1:0] >= HALF));
    assign cf_of = (op_q == MD_OP_MUL) ? (prod[2*WIDTH-1:WIDTH] != '0)
                                       : (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = MD_ST_IDLE;
        end else begin
            case (state)
                MD_ST_IDLE: if (accept) state_nxt = MD_ST_PREP;
                MD_ST_PREP: state_nxt = early_de ? MD_ST_DONE : MD_ST_CALC;
                MD_ST_CALC: if (cnt == '0) state_nxt = MD_ST_FIX;
                MD_ST_FIX:  state_nxt = MD_ST_DONE;
                MD_ST_DONE: if (out_ready) state_nxt = in_valid ? MD_ST_PREP : MD_ST_IDLE;
                default:    state_nxt = MD_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = ~flush & ((state == MD_ST_IDLE) | ((state == MD_ST_DONE) & out_ready));
        busy      = state != MD_ST_IDLE;
        out_valid = state == MD_ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= md_op_e'(op);
            dvd_q <= {opnd_hi, opnd_lo};
            src_q <= opnd_src;
        end
        case (state)
            MD_ST_PREP: begin
                acc    <= is_div ? a_mag : {{WIDTH{1'b0}}, b_mag};
                opb    <= is_div ? b_mag : a_mag[WIDTH-1:0];
                cnt    <= CNT_INIT;
                sign_q <= a_neg ^ b_neg;
                sign_r <= a_neg;
            end
            MD_ST_CALC: begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_lo    <= '0;
            res_hi    <= '0;
            res_cf_of <= 1'b0;
            res_de    <= 1'b0;
        end else if (!flush) begin
            if (state == MD_ST_PREP && early_de) begin
                res_lo    <= '0;
                res_hi    <= '0;
                res_cf_of <= 1'b0;
                res_de    <= 1'b1;
            end else if (state == MD_ST_FIX) begin
                if (is_div) begin
                    res_lo    <= idiv_ovf ? '0 : quot;
                    res_hi    <= idiv_ovf ? '0 : rem;
                    res_cf_of <= 1'b0;
                    res_de    <= idiv_ovf;
                end else begin
                    res_lo    <= prod[WIDTH-1:0];
                    res_hi    <= prod[2*WIDTH-1:WIDTH];
                    res_cf_of <= cf_of;
                    res_de    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: 32-bit and 8-bit instances checked against an arithmetic model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready, sel;
    logic [1:0]  op;
    logic [31:0] opnd_hi, opnd_lo, opnd_src;

    logic        rdy32, ov32, cf32, de32, busy32, rdy8, ov8, cf8, de8, busy8;
    logic [31:0] lo32, hi32;
    logic [7:0]  lo8, hi8;
    logic        iv32, iv8;

    logic [31:0] o_lo, o_hi;
    logic        o_cf, o_de, o_valid, o_ready, o_busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] e_lo, e_hi;
    logic        e_cf, e_de;
    int          e_lat;

    always #5 clk = ~clk;

    assign iv32 = in_valid & sel;
    assign iv8  = in_valid & ~sel;

    muldiv_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv32), .in_ready(rdy32),
        .op(op), .opnd_hi(opnd_hi), .opnd_lo(opnd_lo), .opnd_src(opnd_src),
        .out_valid(ov32), .out_ready(out_ready), .res_lo(lo32), .res_hi(hi32),
        .res_cf_of(cf32), .res_de(de32), .busy(busy32)
    );

    muldiv_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv8), .in_ready(rdy8),
        .op(op), .opnd_hi(opnd_hi[7:0]), .opnd_lo(opnd_lo[7:0]), .opnd_src(opnd_src[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .res_lo(lo8), .res_hi(hi8),
        .res_cf_of(cf8), .res_de(de8), .busy(busy8)
    );

    assign o_lo    = sel ? lo32 : {24'd0, lo8};
    assign o_hi    = sel ? hi32 : {24'd0, hi8};
    assign o_cf    = sel ? cf32 : cf8;
    assign o_de    = sel ? de32 : de8;
    assign o_valid = sel ? ov32 : ov8;
    assign o_ready = sel ? rdy32 : rdy8;
    assign o_busy  = sel ? busy32 : busy8;

    function automatic longint sext(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        if (v[w-1]) return longint'(v | ~m);
        return longint'(v);
    endfunction

    // Reference: exact arithmetic on 64-bit values, then x86 range rules.
    task automatic model(input int w, input logic [1:0] o, input logic [31:0] h, l, s);
        logic [63:0] mask, mask2, a, b, hh, pu, dvd, ua, ub, uq, ur, half;
        longint      p;
        logic        an, bn;
        mask  = (64'd1 << w) - 64'd1;
        mask2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        half  = 64'd1 << (w-1);
        a = {32'd0, l} & mask; b = {32'd0, s} & mask; hh = {32'd0, h} & mask;
        e_lo = 0; e_hi = 0; e_cf = 0; e_de = 0; e_lat = w + 2;
        case (o)
            2'd0: begin
                pu = a * b;
                e_lo = 32'(pu & mask);
                e_hi = 32'((pu >> w) & mask);
                e_cf = e_hi != 0;
            end
            2'd1: begin
                p = sext(a, w) * sext(b, w);
                e_lo = 32'(p & longint'(mask));
                e_hi = 32'((p >>> w) & longint'(mask));
                e_cf = (p < -(longint'(1) << (w-1))) || (p >= (longint'(1) << (w-1)));
            end
            default: begin
                dvd = ((hh << w) | a) & mask2;
                an  = (o == 2'd3) && dvd[2*w-1];
                bn  = (o == 2'd3) && b[w-1];
                ua  = an ? ((~dvd + 64'd1) & mask2) : dvd;
                ub  = bn ? ((~b + 64'd1) & mask) : b;
                e_lat = 1; e_de = 1;
                if (ub != 0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    if (uq <= mask) begin
                        e_lat = w + 2;
                        if (o == 2'd3 && ((an ^ bn) ? (uq > half) : (uq >= half))) begin
                            e_de = 1;
                        end else begin
                            e_de = 0;
                            e_lo = 32'(((an ^ bn) ? (~uq + 64'd1) : uq) & mask);
                            e_hi = 32'((an ? (~ur + 64'd1) : ur) & mask);
                        end
                    end
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic present(input bit s32, input logic [1:0] o, input logic [31:0] h, l, s);
        model(s32 ? 32 : 8, o, h, l, s);
        sel = s32; op = o; opnd_hi = h; opnd_lo = l; opnd_src = s; in_valid = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b expected 1", o_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op = 2'($urandom); opnd_hi = $urandom; opnd_lo = $urandom; opnd_src = $urandom;
    endtask

    task automatic await_result(input string name);
        int lat;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != e_lat) begin errors++; $display("FAIL %s latency got %0d expected %0d", name, lat, e_lat); end
        checks++;
        if (o_lo !== e_lo) begin errors++; $display("FAIL %s res_lo got %h expected %h", name, o_lo, e_lo); end
        checks++;
        if (o_hi !== e_hi) begin errors++; $display("FAIL %s res_hi got %h expected %h", name, o_hi, e_hi); end
        checks++;
        if (o_cf !== e_cf) begin errors++; $display("FAIL %s res_cf_of got %b expected %b", name, o_cf, e_cf); end
        checks++;
        if (o_de !== e_de) begin errors++; $display("FAIL %s res_de got %b expected %b", name, o_de, e_de); end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL %s valid_drop got %b expected 0", name, o_valid); end
    endtask

    task automatic run(input bit s32, input logic [1:0] o, input logic [31:0] h, l, s, input string name);
        present(s32, o, h, l, s);
        await_result(name);
        release_result(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b1;
        op = 2'd0; opnd_hi = 0; opnd_lo = 0; opnd_src = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = (i == 0);
            #1;
            checks++;
            if ({o_valid, o_ready, o_busy, o_lo, o_hi, o_cf, o_de} !== {3'b010, 64'd0, 2'b00}) begin
                errors++;
                $display("FAIL reset_state w%0d got v%b r%b b%b %h %h expected v0 r1 b0 zeros",
                         sel ? 32 : 8, o_valid, o_ready, o_busy, o_lo, o_hi);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run(1, 2'd0, 32'h0, 32'hFFFF_FFFF, 32'h2, "mul32_max");
        run(0, 2'd1, 32'h0, 32'hFD, 32'h05, "imul8_neg");
        run(0, 2'd1, 32'h0, 32'h40, 32'h04, "imul8_ovf");
        run(0, 2'd1, 32'h0, 32'h80, 32'h80, "imul8_minmin");
        run(1, 2'd1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, "imul32_min_neg1");
    endtask

    task automatic test_div();
        run(1, 2'd2, 32'd0, 32'd100, 32'd7, "div32_basic");
        run(1, 2'd2, 32'd0, 32'd123, 32'd0, "div32_zero");
        run(1, 2'd2, 32'd7, 32'd0, 32'd7, "div32_early_ovf");
        run(0, 2'd3, 32'hFF, 32'hF9, 32'h02, "idiv8_neg");
        run(0, 2'd3, 32'hFF, 32'h80, 32'hFF, "idiv8_fix_ovf");
        run(0, 2'd3, 32'hFF, 32'h80, 32'h01, "idiv8_min_quot");
        run(1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h2, "idiv32_neg");
    endtask

    task automatic test_random();
        bit          s32;
        logic [1:0]  o;
        logic [31:0] h, l, s;
        int          w;
        for (int i = 0; i < 60; i++) begin
            s32 = i[0];
            w = s32 ? 32 : 8;
            o = 2'($urandom_range(0, 3));
            h = $urandom; l = $urandom; s = $urandom;
            if (o[1]) begin
                case ($urandom_range(0, 7))
                    0:       s = 32'd0;
                    1, 2:    ;
                    default: h = (o == 2'd3 && l[w-1]) ? 32'hFFFF_FFFF : 32'h0;
                endcase
            end
            run(s32, o, h, l, s, "random");
        end
    endtask

    task automatic test_hold();
        present(1, 2'd2, 32'd0, 32'd1000, 32'd33);
        await_result("hold");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_ready, o_lo, o_hi} !== {2'b10, e_lo, e_hi}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got v%b r%b %h %h expected v1 r0 %h %h",
                         c, o_valid, o_ready, o_lo, o_hi, e_lo, e_hi);
            end
        end
        release_result("hold");
    endtask

    task automatic test_back_to_back();
        present(0, 2'd1, 32'h0, $urandom, $urandom);
        await_result("b2b_first");
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b1;
            present(0, 2'(k + 1), 32'h0, $urandom, $urandom_range(1, 255));
            out_ready = 1'b0;
            await_result("b2b_next");
        end
        release_result("b2b_last");
    endtask

    task automatic test_async_reset();
        present(1, 2'd0, 32'h0, $urandom, $urandom);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_busy, o_ready, o_lo} !== {3'b001, 32'd0}) begin
            errors++;
            $display("FAIL async_rst_calc got v%b b%b r%b lo %h expected v0 b0 r1 lo 0",
                     o_valid, o_busy, o_ready, o_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        present(0, 2'd0, 32'h0, 32'h0F, 32'h03);
        await_result("pre_reset_done");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_busy, o_lo} !== {2'b00, 32'd0}) begin
            errors++;
            $display("FAIL async_rst_done got v%b b%b lo %h expected v0 b0 lo 0", o_valid, o_busy, o_lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1, 2'd0, 32'h0, 32'd12345, 32'd678, "post_reset_mul");
    endtask

    task automatic test_flush();
        present(1, 2'd1, 32'h0, $urandom, $urandom);
        repeat (10) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 2'd0;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b expected 0", o_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({o_busy, o_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle got b%b v%b expected b0 v0", o_busy, o_valid);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_no_accept got busy %b expected 0", o_busy); end
        run(1, 2'd0, 32'h0, $urandom, $urandom, "post_flush_mul");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
